// File: rtl/seq_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_gen                                                          |
// | Purpose  : Serial pattern transmitter, MSB-first, with frame repetition.    |
// |            Optional 0110 frame marker when SEQ_GEN_PREAMBLE_EN is defined.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module seq_gen #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic [CNT_W-1:0] load_rep,
    output logic             x,
    output logic             x_valid,
    output logic             done
);

    localparam int               c_idx_w     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [LEN_W-1:0] c_width_len = LEN_W'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1
`ifdef SEQ_GEN_PREAMBLE_EN
        ,
        ST_PRE  = 2'd2
`endif
    } state_t;

    state_t             r_state, w_state_n;
    logic [WIDTH-1:0]   r_data, w_data_n;
    logic [c_idx_w-1:0] r_len_m1, w_len_m1_n;
    logic [c_idx_w-1:0] r_bit, w_bit_n;
    logic [CNT_W-1:0]   r_rep, w_rep_n;
    logic               r_x, w_x_n;
    logic               r_x_valid, w_x_valid_n;
    logic               r_done, w_done_n;
    logic [c_idx_w-1:0] w_load_len_m1;
    logic [c_idx_w-1:0] w_bit_dec;

`ifdef SEQ_GEN_PREAMBLE_EN
    localparam logic [3:0] c_marker = 4'b0110;
    logic [1:0] r_pre, w_pre_n;
    logic [1:0] w_pre_inc;
    assign w_pre_inc = r_pre + 2'd1;
`endif

    assign w_bit_dec  = r_bit - c_idx_w'(1);
    assign load_ready = (r_state == ST_IDLE);
    assign x          = r_x;
    assign x_valid    = r_x_valid;
    assign done       = r_done;

    // Out-of-range lengths (0 or above WIDTH) fall back to a full-width frame.
    always_comb begin
        if (load_len == '0 || load_len > c_width_len) begin
            w_load_len_m1 = c_idx_w'(WIDTH - 1);
        end else begin
            w_load_len_m1 = c_idx_w'(load_len - LEN_W'(1));
        end
    end

    // Next values describe the bit to be shown during the following cycle.
    always_comb begin
        w_state_n   = r_state;
        w_data_n    = r_data;
        w_len_m1_n  = r_len_m1;
        w_bit_n     = r_bit;
        w_rep_n     = r_rep;
        w_x_n       = 1'b0;
        w_x_valid_n = 1'b0;
        w_done_n    = 1'b0;
`ifdef SEQ_GEN_PREAMBLE_EN
        w_pre_n     = r_pre;
`endif
        case (r_state)
            ST_IDLE: begin
                if (load_valid) begin
                    w_data_n    = load_data;
                    w_len_m1_n  = w_load_len_m1;
                    w_rep_n     = load_rep;
                    w_x_valid_n = 1'b1;
`ifdef SEQ_GEN_PREAMBLE_EN
                    w_state_n   = ST_PRE;
                    w_pre_n     = 2'd0;
                    w_x_n       = c_marker[0];
`else
                    w_state_n   = ST_DATA;
                    w_bit_n     = w_load_len_m1;
                    w_x_n       = load_data[w_load_len_m1];
                    w_done_n    = (w_load_len_m1 == '0) && (load_rep == '0);
`endif
                end
            end
`ifdef SEQ_GEN_PREAMBLE_EN
            ST_PRE: begin
                w_x_valid_n = 1'b1;
                if (r_pre == 2'd3) begin
                    w_state_n = ST_DATA;
                    w_bit_n   = r_len_m1;
                    w_x_n     = r_data[r_len_m1];
                    w_done_n  = (r_len_m1 == '0) && (r_rep == '0);
                end else begin
                    w_pre_n = w_pre_inc;
                    w_x_n   = c_marker[w_pre_inc];
                end
            end
`endif
            ST_DATA: begin
                if (r_bit != '0) begin
                    w_bit_n     = w_bit_dec;
                    w_x_valid_n = 1'b1;
                    w_x_n       = r_data[w_bit_dec];
                    w_done_n    = (r_bit == c_idx_w'(1)) && (r_rep == '0);
                end else if (r_rep != '0) begin
                    // Seamless restart of the next repetition, no idle gap.
                    w_rep_n     = r_rep - CNT_W'(1);
                    w_x_valid_n = 1'b1;
`ifdef SEQ_GEN_PREAMBLE_EN
                    w_state_n   = ST_PRE;
                    w_pre_n     = 2'd0;
                    w_x_n       = c_marker[0];
`else
                    w_bit_n     = r_len_m1;
                    w_x_n       = r_data[r_len_m1];
                    w_done_n    = (r_len_m1 == '0) && (r_rep == CNT_W'(1));
`endif
                end else begin
                    w_state_n = ST_IDLE;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_data    <= '0;
            r_len_m1  <= '0;
            r_bit     <= '0;
            r_rep     <= '0;
            r_x       <= 1'b0;
            r_x_valid <= 1'b0;
            r_done    <= 1'b0;
`ifdef SEQ_GEN_PREAMBLE_EN
            r_pre     <= 2'd0;
`endif
        end else begin
            r_state   <= w_state_n;
            r_data    <= w_data_n;
            r_len_m1  <= w_len_m1_n;
            r_bit     <= w_bit_n;
            r_rep     <= w_rep_n;
            r_x       <= w_x_n;
            r_x_valid <= w_x_valid_n;
            r_done    <= w_done_n;
`ifdef SEQ_GEN_PREAMBLE_EN
            r_pre     <= w_pre_n;
`endif
        end
    end

endmodule
`default_nettype wire
